// File: rtl/rs_issue_scheduler_pkg.sv
// Shared tomasula types for the reservation-station bank: dispatch word,
// ALU operand bundle and station indexing.
package tomasula_types;

  localparam int unsigned NUM_RS      = 4;
  localparam int unsigned ROB_ENTRIES = 8;
  localparam int unsigned TAG_W       = $clog2(ROB_ENTRIES);
  localparam int unsigned DATA_W      = 32;

  typedef logic [$clog2(NUM_RS)-1:0] rs_idx_t;
  typedef logic [TAG_W-1:0]          rob_tag_t;

  // Operation handed to the ALU once both operands are resolved
  typedef struct packed {
    logic [3:0]        op;
    rob_tag_t          tag;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } alu_word;

  // Decoded instruction as written into a reservation station
  typedef struct packed {
    logic [3:0]        op;
    rob_tag_t          tag;
    logic              j_valid;
    rob_tag_t          qj;
    logic [DATA_W-1:0] vj;
    logic              k_valid;
    rob_tag_t          qk;
    logic [DATA_W-1:0] vk;
  } res_word;

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// Dispatch, station and ALU handshake bundle around the issue scheduler.
// The slave modport is the scheduler; the master modport is its surroundings.
interface rs_issue_scheduler_if #(
  parameter int unsigned NUM_RS = tomasula_types::NUM_RS
);
  localparam int unsigned OCC_W = $clog2(NUM_RS) + 1;

  logic                                  flush;
  logic                                  disp_valid;
  tomasula_types::res_word               disp_word;
  logic                                  disp_ready;
  logic [NUM_RS-1:0]                     rs_empty;
  logic [NUM_RS-1:0]                     rs_load;
  tomasula_types::res_word               rs_word;
  logic [NUM_RS-1:0]                     rs_req;
  tomasula_types::alu_word [NUM_RS-1:0]  rs_alu_data;
  logic [NUM_RS-1:0]                     rs_grant;
  logic                                  alu_valid;
  tomasula_types::alu_word               alu_data;
  logic                                  alu_ready;
  logic [OCC_W-1:0]                      rs_occupancy;

  modport master (
    output flush, disp_valid, disp_word, rs_empty, rs_req, rs_alu_data, alu_ready,
    input  disp_ready, rs_load, rs_word, rs_grant, alu_valid, alu_data, rs_occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_word, rs_empty, rs_req, rs_alu_data, alu_ready,
    output disp_ready, rs_load, rs_word, rs_grant, alu_valid, alu_data, rs_occupancy
  );

endinterface

// File: rtl/rs_issue_scheduler_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// N must be a power of two so the index wraps by truncation.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr + IW'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Steers dispatched words into free reservation stations and round-robin
// issues ready stations onto the shared ALU through a holding register.
module rs_issue_scheduler #(
  parameter int unsigned NUM_RS      = tomasula_types::NUM_RS,
  parameter int unsigned ROB_ENTRIES = tomasula_types::ROB_ENTRIES
) (
  input  logic                 clk,
  input  logic                 rst,
  rs_issue_scheduler_if.slave  bus
);
  localparam int unsigned IW    = $clog2(NUM_RS);
  localparam int unsigned OCC_W = IW + 1;

  if (NUM_RS < 2 || (NUM_RS & (NUM_RS - 1)) != 0 ||
      ROB_ENTRIES != tomasula_types::ROB_ENTRIES) begin : g_bad_cfg
    $error("rs_issue_scheduler: unsupported NUM_RS/ROB_ENTRIES");
  end

  logic [NUM_RS-1:0] free_mask;
  logic [NUM_RS-1:0] disp_grant;
  logic [NUM_RS-1:0] iss_grant;
  logic [NUM_RS-1:0] rs_grant_q;
  logic [IW-1:0]     disp_idx;
  logic [IW-1:0]     iss_idx;
  logic [IW-1:0]     alloc_ptr;
  logic [IW-1:0]     rr_ptr;
  logic              disp_any;
  logic              iss_any;
  logic              out_free;
  logic              issue_fire;
  logic [OCC_W-1:0]  empty_cnt;

  rr_arbiter #(.N(NUM_RS)) u_disp_arb (
    .req   (free_mask),
    .ptr   (alloc_ptr),
    .grant (disp_grant),
    .idx   (disp_idx),
    .any   (disp_any)
  );

  rr_arbiter #(.N(NUM_RS)) u_issue_arb (
    .req   (bus.rs_req),
    .ptr   (rr_ptr),
    .grant (iss_grant),
    .idx   (iss_idx),
    .any   (iss_any)
  );

  // A station granted last cycle is still draining and reports empty too early
  always_comb begin
    free_mask      = bus.rs_empty & ~rs_grant_q;
    out_free       = ~bus.alu_valid | bus.alu_ready;
    issue_fire     = out_free & ~bus.flush & iss_any;
    bus.disp_ready = disp_any & ~bus.flush;
    bus.rs_load    = (bus.disp_valid & bus.disp_ready) ? disp_grant : '0;
    bus.rs_grant   = issue_fire ? iss_grant : '0;
    bus.rs_word    = bus.disp_word;
  end

  always_comb begin
    empty_cnt = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      empty_cnt = empty_cnt + OCC_W'(bus.rs_empty[i]);
    end
  end

  // Output register holds alu_data until accepted; flush only drops valid
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_valid    <= 1'b0;
      bus.alu_data     <= '0;
      bus.rs_occupancy <= '0;
      rr_ptr           <= '0;
      alloc_ptr        <= '0;
      rs_grant_q       <= '0;
    end else begin
      rs_grant_q <= bus.rs_grant;
      if (|bus.rs_load) alloc_ptr <= disp_idx + IW'(1);
      if (issue_fire) begin
        bus.alu_valid <= 1'b1;
        bus.alu_data  <= bus.rs_alu_data[iss_idx];
        rr_ptr        <= iss_idx + IW'(1);
      end else if (bus.flush || bus.alu_ready) begin
        bus.alu_valid <= 1'b0;
      end
      bus.rs_occupancy <= OCC_W'(NUM_RS) - empty_cnt;
    end
  end

endmodule
